// File: rtl/nn_result_writeback.sv
// rtl/nn_result_writeback.sv - packs z RAM results into cache lines, writes them to host, then a flag line
// Waits for every write ack before pulsing done.
module nn_result_writeback #(
  parameter int NUM_WORDS = 64,
  parameter int WORD_W    = 32,
  parameter int ADDR_W    = 6,
  parameter int LINE_W    = 512,
  parameter int CL_ADDR_W = 42,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CL_ADDR_W-1:0] base_addr,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    z_rd_addr,
  input  logic [WORD_W-1:0]    z_dout,
  output logic                 wr_valid,
  output logic [CL_ADDR_W-1:0] wr_addr,
  output logic [LINE_W-1:0]    wr_data,
  input  logic                 wr_almfull,
  input  logic                 wr_rsp_valid
);
  localparam int WPL       = LINE_W / WORD_W;
  localparam int NUM_LINES = NUM_WORDS / WPL;
  localparam int KW        = $clog2(WPL) + 1;
  localparam int RW        = $clog2(NUM_LINES + 2);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_FLAG, S_DRAIN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [ADDR_W-1:0]      z_rd_addr_q, z_rd_addr_d;
  logic                   wr_valid_q, wr_valid_d;
  logic [CL_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [LINE_W-1:0]      wr_data_q, wr_data_d;
  logic [CL_ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]      line_idx_q, line_idx_d;
  logic [KW-1:0]          rd_cnt_q, rd_cnt_d;
  logic [KW-1:0]          cap_cnt_q, cap_cnt_d;
  logic [RD_LAT:0]        pipe_q, pipe_d;
  logic [LINE_W-1:0]      line_q, line_d;
  logic [RW-1:0]          rsp_cnt_q, rsp_cnt_d;

  assign busy      = busy_q;
  assign done      = done_q;
  assign z_rd_addr = z_rd_addr_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    z_rd_addr_d = z_rd_addr_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    base_d      = base_q;
    line_idx_d  = line_idx_q;
    rd_cnt_d    = rd_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    line_d      = line_q;
    rsp_cnt_d   = rsp_cnt_q;
    // bit 0 marks an address on z_rd_addr; bit RD_LAT marks its data on z_dout
    pipe_d      = {pipe_q[RD_LAT-1:0], 1'b0};

    if (state_q inside {S_FILL, S_ISSUE, S_FLAG, S_DRAIN} && wr_rsp_valid &&
        rsp_cnt_q != RW'(NUM_LINES + 1)) begin
      rsp_cnt_d = rsp_cnt_q + RW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d     = base_addr;
          busy_d     = 1'b1;
          line_idx_d = '0;
          rsp_cnt_d  = '0;
          rd_cnt_d   = '0;
          cap_cnt_d  = '0;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (rd_cnt_q != KW'(WPL)) begin
          z_rd_addr_d = ADDR_W'(line_idx_q * WPL) + ADDR_W'(rd_cnt_q);
          rd_cnt_d    = rd_cnt_q + KW'(1);
          pipe_d[0]   = 1'b1;
        end
        if (pipe_q[RD_LAT]) begin
          line_d[int'(cap_cnt_q) * WORD_W +: WORD_W] = z_dout;
          cap_cnt_d = cap_cnt_q + KW'(1);
          if (cap_cnt_q == KW'(WPL - 1)) state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!wr_almfull) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = base_q + CL_ADDR_W'(line_idx_q);
          wr_data_d  = line_q;
          if (line_idx_q == ADDR_W'(NUM_LINES - 1)) begin
            state_d = S_FLAG;
          end else begin
            line_idx_d = line_idx_q + ADDR_W'(1);
            rd_cnt_d   = '0;
            cap_cnt_d  = '0;
            state_d    = S_FILL;
          end
        end
      end
      S_FLAG: begin
        if (!wr_almfull) begin
          wr_valid_d         = 1'b1;
          wr_addr_d          = base_q + CL_ADDR_W'(NUM_LINES);
          wr_data_d          = '0;
          wr_data_d[63:0]    = 64'h1;
          wr_data_d[95:64]   = 32'(NUM_WORDS);
          state_d            = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Uses the updated count so done follows the last ack by one cycle.
        if (rsp_cnt_d == RW'(NUM_LINES + 1)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      z_rd_addr_q <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      base_q      <= '0;
      line_idx_q  <= '0;
      rd_cnt_q    <= '0;
      cap_cnt_q   <= '0;
      pipe_q      <= '0;
      line_q      <= '0;
      rsp_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      z_rd_addr_q <= z_rd_addr_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      base_q      <= base_d;
      line_idx_q  <= line_idx_d;
      rd_cnt_q    <= rd_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      pipe_q      <= pipe_d;
      line_q      <= line_d;
      rsp_cnt_q   <= rsp_cnt_d;
    end
  end
endmodule

// File: tb/tb_nn_result_writeback.sv
// tb/tb_nn_result_writeback.sv - scoreboard bench for nn_result_writeback
// Second instance runs with a 2-cycle z RAM.
module tb_nn_result_writeback;
  localparam int NW = 64, WW = 32, AW = 6, LW = 512, CW = 42, NL = 4;

  typedef struct packed {
    logic [CW-1:0] addr;
    logic [LW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, start2;
  logic [CW-1:0] base_addr, base_addr2;
  logic          busy, done, busy2, done2;
  logic [AW-1:0] z_rd_addr, z_rd_addr2;
  logic [WW-1:0] z_dout, z_dout2, z_mid2;
  logic          wr_valid, wr_valid2;
  logic [CW-1:0] wr_addr, wr_addr2;
  logic [LW-1:0] wr_data, wr_data2;
  logic          wr_almfull, wr_almfull2;
  logic          wr_rsp_valid, wr_rsp_valid2;

  int cyc = 0;
  int compared = 0, mismatched = 0;
  int wr_seen = 0, acks_sent = 0, wr_seen2 = 0, acks_sent2 = 0;
  int done_cnt = 0, done2_cnt = 0, done_cyc = 0, last_ack_cyc = 0;
  int stray_req = 0, stray_done = 0;
  bit ack_hold = 0, af_mode = 0;
  wr_t exp_q[$], exp_q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) z_dout <= 32'(z_rd_addr) + 32'd1;
  always @(posedge clk) begin
    z_mid2  <= 32'(z_rd_addr2) + 32'd1;
    z_dout2 <= z_mid2;
  end

  nn_result_writeback #(.NUM_WORDS(NW), .WORD_W(WW), .ADDR_W(AW), .LINE_W(LW),
                        .CL_ADDR_W(CW), .RD_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .busy(busy),
    .done(done), .z_rd_addr(z_rd_addr), .z_dout(z_dout), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_almfull(wr_almfull),
    .wr_rsp_valid(wr_rsp_valid));

  nn_result_writeback #(.NUM_WORDS(NW), .WORD_W(WW), .ADDR_W(AW), .LINE_W(LW),
                        .CL_ADDR_W(CW), .RD_LAT(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .base_addr(base_addr2), .busy(busy2),
    .done(done2), .z_rd_addr(z_rd_addr2), .z_dout(z_dout2), .wr_valid(wr_valid2),
    .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_almfull(wr_almfull2),
    .wr_rsp_valid(wr_rsp_valid2));

  function automatic logic [LW-1:0] exp_line(input int n);
    logic [LW-1:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = 32'(n * 16 + k + 1);
    return l;
  endfunction

  function automatic logic [LW-1:0] flag_line();
    logic [LW-1:0] l;
    l = '0;
    l[63:0]  = 64'h1;
    l[95:64] = 32'd64;
    return l;
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_run(input logic [CW-1:0] base, input bit second);
    wr_t e;
    for (int n = 0; n <= NL; n++) begin
      e.addr = base + CW'(n);
      e.data = (n == NL) ? flag_line() : exp_line(n);
      if (second) exp_q2.push_back(e);
      else exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [CW-1:0] base);
    base_addr = base;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    check(name, LW'(done_cnt >= target), LW'(1));
  endtask

  // Monitor: pops the scoreboard on every write, tracks done pulses.
  initial begin
    bit af_prev = 0, done_prev = 0, done2_prev = 0;
    wr_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (wr_valid) begin
          check("wr_after_almfull_low", LW'(af_prev), LW'(0));
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_write: got addr %0h expected no write", wr_addr);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", LW'(wr_addr), LW'(e.addr));
            check("wr_data", wr_data, e.data);
          end
          wr_seen++;
        end
        if (wr_valid2) begin
          if (exp_q2.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_write_lat2: got addr %0h expected no write", wr_addr2);
          end else begin
            e = exp_q2.pop_front();
            check("wr_addr_lat2", LW'(wr_addr2), LW'(e.addr));
            check("wr_data_lat2", wr_data2, e.data);
          end
          wr_seen2++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check("busy_at_done", LW'(busy), LW'(1));
          check("done_one_cycle", LW'(done_prev), LW'(0));
        end
        if (done2) begin
          done2_cnt++;
          check("done_one_cycle_lat2", LW'(done2_prev), LW'(0));
        end
      end
      af_prev    = wr_almfull;
      done_prev  = done;
      done2_prev = done2;
    end
  end

  // Host model: acks writes one per cycle, drives almost-full pattern.
  initial begin
    wr_rsp_valid  = 1'b0;
    wr_rsp_valid2 = 1'b0;
    wr_almfull    = 1'b0;
    wr_almfull2   = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        acks_sent    = wr_seen;
        acks_sent2   = wr_seen2;
        wr_rsp_valid = 1'b0;
      end else if (stray_done != stray_req) begin
        wr_rsp_valid = 1'b1;
        stray_done++;
      end else if (!ack_hold && acks_sent < wr_seen) begin
        wr_rsp_valid = 1'b1;
        acks_sent++;
        last_ack_cyc = cyc;
      end else begin
        wr_rsp_valid = 1'b0;
      end
      wr_rsp_valid2 = 1'b0;
      if (!reset && acks_sent2 < wr_seen2) begin
        wr_rsp_valid2 = 1'b1;
        acks_sent2++;
      end
      wr_almfull = af_mode && (cyc % 21 != 20);
    end
  end

  initial begin
    int n, w0;
    reset = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    base_addr = '0;
    base_addr2 = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("reset_busy", LW'(busy), LW'(0));
    check("reset_done", LW'(done), LW'(0));
    check("reset_wr_valid", LW'(wr_valid), LW'(0));
    check("reset_z_rd_addr", LW'(z_rd_addr), LW'(0));

    // 1: basic run
    push_run(42'h1000, 1'b0);
    pulse_start(42'h1000);
    wait_done(1, 1000, "t1_done");
    check("t1_busy_clear", LW'(busy), LW'(0));
    check("t1_all_writes", LW'(exp_q.size()), LW'(0));

    // 2: almost-full back-pressure
    af_mode = 1;
    push_run(42'h2000, 1'b0);
    pulse_start(42'h2000);
    wait_done(2, 3000, "t2_done");
    af_mode = 0;
    check("t2_all_writes", LW'(exp_q.size()), LW'(0));

    // 3: acks held until 50 cycles after the flag
    ack_hold = 1;
    w0 = wr_seen;
    push_run(42'h1000, 1'b0);
    pulse_start(42'h1000);
    n = 0;
    while (wr_seen < w0 + NL + 1 && n < 1000) begin
      step();
      n++;
    end
    check("t3_flag_written", LW'(wr_seen), LW'(w0 + NL + 1));
    repeat (50) begin
      step();
      check("t3_busy_held", LW'(busy), LW'(1));
      check("t3_no_done", LW'(done_cnt), LW'(2));
    end
    ack_hold = 0;
    wait_done(3, 100, "t3_done");
    check("t3_done_latency", LW'(done_cyc), LW'(last_ack_cyc + 1));

    // 4: start while busy and stray acks outside a run
    stray_req++;
    repeat (2) step();
    w0 = wr_seen;
    push_run(42'h5000, 1'b0);
    pulse_start(42'h5000);
    repeat (10) step();
    pulse_start(42'h7000);
    wait_done(4, 1000, "t4_done");
    stray_req++;
    repeat (40) step();
    check("t4_single_done", LW'(done_cnt), LW'(4));
    check("t4_idle", LW'(busy), LW'(0));
    check("t4_write_count", LW'(wr_seen - w0), LW'(NL + 1));
    check("t4_all_writes", LW'(exp_q.size()), LW'(0));

    // 5: reset during line 2 fill, then wrapping base
    push_run(42'h9000, 1'b0);
    pulse_start(42'h9000);
    n = 0;
    while (z_rd_addr != 6'd34 && n < 1000) begin
      step();
      n++;
    end
    check("t5_reached_line2", LW'(z_rd_addr), LW'(34));
    reset = 1'b1;
    step();
    check("t5_rst_wr_valid", LW'(wr_valid), LW'(0));
    check("t5_rst_busy", LW'(busy), LW'(0));
    check("t5_rst_z_rd_addr", LW'(z_rd_addr), LW'(0));
    reset = 1'b0;
    check("t5_lines_before_reset", LW'(exp_q.size()), LW'(3));
    exp_q.delete();
    repeat (5) step();
    push_run(42'h3FFFFFFFFFE, 1'b0);
    pulse_start(42'h3FFFFFFFFFE);
    wait_done(5, 1000, "t5_done");
    check("t5_all_writes", LW'(exp_q.size()), LW'(0));

    // 6: RD_LAT=2 instance
    push_run(42'h1000, 1'b1);
    base_addr2 = 42'h1000;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    n = 0;
    while (done2_cnt < 1 && n < 1000) begin
      step();
      n++;
    end
    check("t6_done", LW'(done2_cnt), LW'(1));
    check("t6_all_writes", LW'(exp_q2.size()), LW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
